// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Segment-side driver for a 3-digit multiplexed 7-segment display.
// It generates its own digit scan, shows the matching segment pattern for the
// active digit, and inserts dead time at the start of every digit slot so the
// previous digit's pattern cannot ghost onto the next one.
// New digits arrive through a valid/ready handshake. They land in a pending
// register and move into the displayed (shadow) register only at the end of a
// full frame, so a frame never mixes old and new digits.
//
// Parameters
//   SCAN_DIV   clocks per digit slot (4 .. 2^20)
//   BLANK_CYC  dead-time clocks at the start of each slot (1 .. SCAN_DIV-2)
//   ACTIVE_LOW 1: o_an/o_seg/o_dp_out are low-true at the pins, 0: high-true
//
// Ports
//   i_clk          system clock
//   i_rst          synchronous active-high reset
//   i_load_valid   producer offers i_digits / i_dp
//   o_load_ready   block can accept (transfer when valid && ready)
//   i_digits       {d2,d1,d0} hex nibbles, d0 is the rightmost digit
//   i_dp           decimal point per digit, bit i = digit i, 1 = lit
//   o_an           one-hot digit enable, o_an[i] = digit i
//   o_seg          {g,f,e,d,c,b,a}
//   o_dp_out       decimal point of the active digit
//   o_frame_done   1-cycle pulse at the end of each 3-digit frame
//
// Optional feature
//   LEADING_ZERO_BLANK_EN  when defined, leading zero digits (2, then 1) stay
//                          dark unless their decimal point is set.
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int SCAN_DIV   = 27000,
    parameter int BLANK_CYC  = 270,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load_valid,
    output logic        o_load_ready,
    input  logic [11:0] i_digits,
    input  logic [2:0]  i_dp,
    output logic [2:0]  o_an,
    output logic [6:0]  o_seg,
    output logic        o_dp_out,
    output logic        o_frame_done
);

    localparam int             CW        = $clog2(SCAN_DIV);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]  CNT_BLANK = CW'(BLANK_CYC);

    // Pin levels that mean "off" for the chosen polarity.
    localparam logic [2:0]     AN_OFF    = {3{ACTIVE_LOW}};
    localparam logic [6:0]     SEG_OFF   = {7{ACTIVE_LOW}};
    localparam logic           DP_OFF    = ACTIVE_LOW;

    typedef enum logic [1:0] {
        SLOT_0 = 2'd0,
        SLOT_1 = 2'd1,
        SLOT_2 = 2'd2
    } slot_t;

    logic [CW-1:0] r_cnt;
    slot_t         r_slot;
    logic [11:0]   r_shadow;
    logic [2:0]    r_dpShadow;
    logic [11:0]   r_pend;
    logic [2:0]    r_pendDp;
    logic          r_pendFull;
    logic [2:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dpOut;
    logic          r_frameDone;

    logic          w_frameEnd;
    logic          w_inBlank;
    logic [3:0]    w_nibble;
    logic          w_dpBit;
    logic [2:0]    w_anOneHot;
    logic          w_lit;
    logic [6:0]    w_segLogic;

    assign w_frameEnd   = (r_cnt == CNT_LAST) && (r_slot == SLOT_2);
    assign w_inBlank    = (r_cnt < CNT_BLANK);
    assign o_load_ready = !r_pendFull;
    assign o_an         = r_an;
    assign o_seg        = r_seg;
    assign o_dp_out     = r_dpOut;
    assign o_frame_done = r_frameDone;

    // Select the nibble, decimal point and anode for the slot being scanned,
    // and decide whether that digit is lit at all.
    always_comb begin
        w_nibble   = r_shadow[3:0];
        w_dpBit    = r_dpShadow[0];
        w_anOneHot = 3'b001;
        w_lit      = 1'b1;
        case (r_slot)
            SLOT_1: begin
                w_nibble   = r_shadow[7:4];
                w_dpBit    = r_dpShadow[1];
                w_anOneHot = 3'b010;
            end
            SLOT_2: begin
                w_nibble   = r_shadow[11:8];
                w_dpBit    = r_dpShadow[2];
                w_anOneHot = 3'b100;
            end
            default: ;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        // A digit is a leading zero only if every digit to its left is zero;
        // a set decimal point always keeps the digit visible.
        case (r_slot)
            SLOT_2:  w_lit = (r_shadow[11:8] != 4'h0) || r_dpShadow[2];
            SLOT_1:  w_lit = (r_shadow[11:4] != 8'h00) || r_dpShadow[1];
            default: w_lit = 1'b1;
        endcase
`endif
    end

    // Hex to logical segment pattern, bit 0 = segment a.
    always_comb begin
        w_segLogic = 7'h00;
        case (w_nibble)
            4'h0: w_segLogic = 7'h3F;
            4'h1: w_segLogic = 7'h06;
            4'h2: w_segLogic = 7'h5B;
            4'h3: w_segLogic = 7'h4F;
            4'h4: w_segLogic = 7'h66;
            4'h5: w_segLogic = 7'h6D;
            4'h6: w_segLogic = 7'h7D;
            4'h7: w_segLogic = 7'h07;
            4'h8: w_segLogic = 7'h7F;
            4'h9: w_segLogic = 7'h6F;
            4'hA: w_segLogic = 7'h77;
            4'hB: w_segLogic = 7'h7C;
            4'hC: w_segLogic = 7'h39;
            4'hD: w_segLogic = 7'h5E;
            4'hE: w_segLogic = 7'h79;
            4'hF: w_segLogic = 7'h71;
            default: w_segLogic = 7'h00;
        endcase
    end

    // Scan counters, double buffering and registered pin drive.
    // Pins are computed from the current (slot, cnt), so they lag it by one
    // cycle. The frame-end transfer only moves data that was already pending
    // before this edge; a load accepted on the same edge waits a full frame.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt       <= '0;
            r_slot      <= SLOT_0;
            r_shadow    <= '0;
            r_dpShadow  <= '0;
            r_pend      <= '0;
            r_pendDp    <= '0;
            r_pendFull  <= 1'b0;
            r_frameDone <= 1'b0;
            r_an        <= AN_OFF;
            r_seg       <= SEG_OFF;
            r_dpOut     <= DP_OFF;
        end else begin
            if (r_cnt == CNT_LAST) begin
                r_cnt <= '0;
                case (r_slot)
                    SLOT_0:  r_slot <= SLOT_1;
                    SLOT_1:  r_slot <= SLOT_2;
                    default: r_slot <= SLOT_0;
                endcase
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_frameEnd) begin
                r_pendFull <= 1'b0;
                if (r_pendFull) begin
                    r_shadow   <= r_pend;
                    r_dpShadow <= r_pendDp;
                end
            end

            if (i_load_valid && !r_pendFull) begin
                r_pend     <= i_digits;
                r_pendDp   <= i_dp;
                r_pendFull <= 1'b1;
            end

            r_frameDone <= w_frameEnd;

            if (w_inBlank || !w_lit) begin
                r_an    <= AN_OFF;
                r_seg   <= SEG_OFF;
                r_dpOut <= DP_OFF;
            end else begin
                r_an    <= w_anOneHot ^ AN_OFF;
                r_seg   <= w_segLogic ^ SEG_OFF;
                r_dpOut <= w_dpBit ^ DP_OFF;
            end
        end
    end

endmodule
